// File: rtl/mix_columns_engine.sv
// mix_columns_engine: AES MixColumns / InvMixColumns on a 128-bit state, COLS_PER_CYCLE columns per clock.
// Latency: 4/COLS_PER_CYCLE + OUT_REG cycles counting the accept cycle; peak one block per 4/COLS_PER_CYCLE + 1 cycles.
// Backpressure: the result is held stable until out_ready; a new block can be taken on the output handshake cycle.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1,
  parameter int OUT_REG        = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d;
  logic         mode_q, mode_d;
  logic         accept;
  logic         last_grp;

  // Doubling in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the circulant matrix. Each input byte is doubled three
  // times once, and every coefficient product is an XOR of those multiples, so
  // the doubling chain is shared by all four output rows.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  dbl [4][4];
    logic [3:0]  coef [4];
    logic [7:0]  acc;
    logic [31:0] res;
    logic [1:0]  ci;
    coef[0] = inv ? 4'he : 4'h2;
    coef[1] = inv ? 4'hb : 4'h3;
    coef[2] = inv ? 4'hd : 4'h1;
    coef[3] = inv ? 4'h9 : 4'h1;
    for (int k = 0; k < 4; k++) begin
      dbl[k][0] = col[31-8*k -: 8];
      for (int j = 1; j < 4; j++) dbl[k][j] = xtime(dbl[k][j-1]);
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int k = 0; k < 4; k++) begin
        ci = 2'(k - r);
        for (int j = 0; j < 4; j++) begin
          if (coef[ci][j]) acc ^= dbl[k][j];
        end
      end
      res[31-8*r -: 8] = acc;
    end
    return res;
  endfunction

  assign accept   = in_valid && in_ready;
  assign last_grp = ({1'b0, cnt_q} + 3'(COLS_PER_CYCLE)) == 3'd4;

  // With the bypass option the final group's result is visible while it is being written.
  assign state_out = (OUT_REG == 0 && state_q == RUN) ? work_d : work_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: a handshake during the bypassed last group skips DONE entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_grp) state_d = (OUT_REG == 0 && out_ready) ? IDLE : DONE;
      DONE:    if (out_ready) state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: DONE only takes a new block when the current result leaves.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        busy      = 1'b1;
        out_valid = (OUT_REG == 0) && last_grp;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Datapath next-state: latch on accept, otherwise transform the current column group in place.
  always_comb begin
    logic [1:0] col;
    col    = 2'd0;
    work_d = work_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    if (accept) begin
      work_d = state_in;
      mode_d = mode;
      cnt_d  = 2'd0;
    end else if (state_q == RUN) begin
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        col = cnt_q + 2'(g);
        work_d[127-32*col -: 32] = mix_col(work_q[127-32*col -: 32], mode_q);
      end
      cnt_d = cnt_q + 2'(COLS_PER_CYCLE);
    end
  end

  // Working state, latched mode and column counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      mode_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      work_q <= work_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
